stream_serializer: RTL and testbench
====================================

Name: stream_serializer

Overview:
Parametrised, single-clock wide-to-narrow serializer for the Haraka-S datapath. It converts IN_W-bit words (hash state/digest) into a stream of OUT_W-bit words, with a per-frame length and word order. Valid/ready handshakes sit on both sides. A one-frame pending buffer lets back-to-back frames stream without bubbles. It replaces the fixed byte serializer that needed a separate fast bit clock.

Parameters:
IN_W, 256, input frame width in bits; must be a multiple of OUT_W
OUT_W, 8, output word width in bits
MAX_WORDS, IN_W/OUT_W, words per full frame (derived, 32 by default)
LEN_W, $clog2(MAX_WORDS+1), width of the length field (6 by default)

Ports:
clk  input  1  sole clock
reset  input  1  synchronous, active-high reset
in_data  input  IN_W  frame to serialize
in_len  input  LEN_W  number of OUT_W words to emit from the frame
in_msb_first  input  1  1: first word = in_data[IN_W-1 -: OUT_W]; 0: first word = in_data[OUT_W-1:0]
in_valid  input  1  frame offered
in_ready  output  1  frame can be accepted
out_data  output  OUT_W  current serial word (registered)
out_valid  output  1  out_data valid (registered)
out_last  output  1  final word of the frame (registered)
out_ready  input  1  downstream accepts out_data
busy  output  1  active or pending frame present

Behaviour:
- Reset: sampled on posedge clk. out_valid=0, out_last=0, out_data=0, busy=0, in_ready=0 while reset is high. Reset clears all state, including a partially sent frame and the pending buffer; no words from dropped frames appear afterwards. in_ready=1 on the first cycle after reset is released.
- State: active shift register plus count; pending register with in_len and in_msb_first captured. FSM states: EMPTY (nothing held), ACTIVE (active frame only), FULL (active + pending).
- in_ready = reset ? 0 : (state != FULL). It is combinational from state only; it never depends on in_valid or out_ready.
- Accept: in_valid && in_ready. Length, word order and data are all captured at acceptance.
  - If active is empty, or its last word handshakes in the same cycle, the frame loads into active.
  - Otherwise the frame loads into pending.
- Latency: the first word appears on out_data with out_valid=1 in the cycle after acceptance.
- Output handshake: out_valid && out_ready advances to the next word. While out_ready=0, out_data, out_last and out_valid hold stable.
- Words are emitted in order 0..len-1 per the captured order; the remaining bits of in_data are ignored. out_last=1 exactly with word len-1.
- Frame boundaries with no bubbles:
  - On the last-word handshake with pending full, pending moves to active and its word 0 is presented the next cycle.
  - If pending is empty and a new frame is accepted in that same cycle, it goes straight to active.
  - Throughput is 1 word/cycle sustained.
- in_len=0: the frame is accepted (consumes a handshake), produces no output and does not occupy a slot.
- in_len>MAX_WORDS: clamped to MAX_WORDS.
- in_len=1: a single word with out_last=1.
- FSM transitions:
  - EMPTY->ACTIVE on accept (len>0).
  - ACTIVE->EMPTY on last handshake with no accept.
  - ACTIVE->FULL on accept while not finishing.
  - ACTIVE->ACTIVE on last handshake plus accept.
  - FULL->ACTIVE on last handshake.
- busy = (state != EMPTY).

Decomposition:
- serializer_pkg holds the default IN_W/OUT_W, the derived MAX_WORDS/LEN_W functions, and the typedef ser_state_e {EMPTY, ACTIVE, FULL}.
- A frame record struct (data, len, msb_first) is defined in the package and used for both the active and pending registers.
- No sub-module is required. The word-select/shift logic stays in a single always_ff with a combinational next-state block.

Test Plan:
- Reset then accept 256'h9b26...4076, len=32, msb_first=1, out_ready=1 -> 32 consecutive cycles of words 9b,26,a9,...,40,76; out_last only on 76; in_ready stays 1.
- Same frame, msb_first=0, len=4 -> 76,40,f3,c4, with out_last on c4; then out_valid=0 and busy=0.
- Frames A=9b26...4076 and B=303f...8d5a both with len=32, in_valid held high -> B accepted while A streams (state FULL, in_ready=0). B's first word 30 follows A's 76 on the next cycle with no gap. 64 words total in 64 cycles.
- out_ready toggled 1,0,0,1 during a frame -> out_data is held across the stalled cycles; no word is skipped or duplicated.
- in_len=0 then in_len=40 (clamped to 32) -> no output for the first, 32 words for the second; in_len=1 gives one word with out_last=1.
- Assert reset at word 10 of a frame with pending full -> the next cycle has out_valid=0, busy=0; after release only newly accepted frames appear.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the Haraka-S stream serializer.
//
// Contents:
//   DEF_IN_W / DEF_OUT_W      default frame and output word widths
//   calc_max_words()          words per full frame
//   calc_len_w()              width of a length field that can hold MAX_WORDS
//   ser_state_e               occupancy FSM: EMPTY, ACTIVE, FULL
//   frame_t                   one captured frame (data, length, word order),
//                             used for both the active and pending slots.
//                             It is sized from the package defaults, so a
//                             different IN_W/OUT_W is set here, not per
//                             instance.
package serializer_pkg;

    localparam int DEF_IN_W  = 256;
    localparam int DEF_OUT_W = 8;

    function automatic int calc_max_words(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    function automatic int calc_len_w(input int max_words);
        return $clog2(max_words + 1);
    endfunction

    localparam int DEF_MAX_WORDS = calc_max_words(DEF_IN_W, DEF_OUT_W);
    localparam int DEF_LEN_W     = calc_len_w(DEF_MAX_WORDS);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } ser_state_e;

    typedef struct packed {
        logic [DEF_IN_W-1:0]  data;
        logic [DEF_LEN_W-1:0] len;
        logic                 msb_first;
    } frame_t;

endpackage

// File: rtl/stream_serializer.sv
// Wide-to-narrow serializer: accepts IN_W-bit frames and emits up to
// MAX_WORDS OUT_W-bit words per frame, in MSB-first or LSB-first order.
// One active frame is streamed while a second may wait in a pending slot,
// so consecutive frames follow each other with no idle cycle.
//
// Ports:
//   clk           sole clock
//   reset         synchronous, active-high; drops active and pending frames
//   in_data       frame to serialize
//   in_len        words to emit (0 = drop frame, >MAX_WORDS clamps)
//   in_msb_first  1: first word is the top OUT_W bits; 0: the bottom OUT_W bits
//   in_valid      frame offered
//   in_ready      frame can be accepted (depends on state and reset only)
//   out_data      current output word (registered)
//   out_valid     out_data valid (registered)
//   out_last      out_data is the final word of its frame (registered)
//   out_ready     downstream accepts out_data
//   busy          an active or pending frame is held
module stream_serializer
    import serializer_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int MAX_WORDS = calc_max_words(IN_W, OUT_W),
    parameter int LEN_W     = calc_len_w(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_msb_first,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    // Word presented first from a frame image, according to its order.
    function automatic logic [OUT_W-1:0] first_word(input logic [IN_W-1:0] d,
                                                    input logic          msb);
        return msb ? d[IN_W-1 -: OUT_W] : d[OUT_W-1:0];
    endfunction

    // Frame image with the first word removed, so the next word moves into
    // the position first_word() reads.
    function automatic logic [IN_W-1:0] drop_word(input logic [IN_W-1:0] d,
                                                  input logic          msb);
        return msb ? (d << OUT_W) : (d >> OUT_W);
    endfunction

    ser_state_e       state_q, state_d;
    frame_t           act_q;        // len = words still to present after out_data_q
    frame_t           pend_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic [LEN_W-1:0] len_clamped;
    frame_t           in_frame;
    frame_t           load_src;
    logic             accept, accept_nz, word_hs, last_hs;
    logic             load_in, load_from_pend, store_pend, advance, go_idle;

    assign len_clamped = (in_len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : in_len;
    assign in_frame    = '{data: in_data, len: len_clamped, msb_first: in_msb_first};

    assign in_ready  = !reset && (state_q != FULL);
    assign accept    = in_valid && in_ready;
    // A zero-length frame completes its handshake but never takes a slot.
    assign accept_nz = accept && (len_clamped != '0);
    assign word_hs   = out_valid_q && out_ready;
    assign last_hs   = word_hs && out_last_q;

    always_comb begin
        state_d        = state_q;
        load_in        = 1'b0;
        load_from_pend = 1'b0;
        store_pend     = 1'b0;
        advance        = 1'b0;
        go_idle        = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept_nz) begin
                    state_d = ACTIVE;
                    load_in = 1'b1;
                end
            end
            ACTIVE: begin
                if (last_hs) begin
                    // A frame arriving on the closing handshake goes
                    // straight to the active slot.
                    if (accept_nz) begin
                        load_in = 1'b1;
                    end else begin
                        state_d = EMPTY;
                        go_idle = 1'b1;
                    end
                end else begin
                    advance = word_hs;
                    if (accept_nz) begin
                        state_d    = FULL;
                        store_pend = 1'b1;
                    end
                end
            end
            FULL: begin
                if (last_hs) begin
                    state_d        = ACTIVE;
                    load_from_pend = 1'b1;
                end else begin
                    advance = word_hs;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign load_src = load_from_pend ? pend_q : in_frame;

    // Frame images are not cleared by reset; the state and output flags
    // are, which is enough to guarantee no stale word reappears.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_in || load_from_pend) begin
                out_data_q      <= first_word(load_src.data, load_src.msb_first);
                act_q.data      <= drop_word(load_src.data, load_src.msb_first);
                act_q.len       <= load_src.len - DEF_LEN_W'(1);
                act_q.msb_first <= load_src.msb_first;
                out_valid_q     <= 1'b1;
                out_last_q      <= (load_src.len == DEF_LEN_W'(1));
            end else if (advance) begin
                out_data_q <= first_word(act_q.data, act_q.msb_first);
                act_q.data <= drop_word(act_q.data, act_q.msb_first);
                act_q.len  <= act_q.len - DEF_LEN_W'(1);
                out_last_q <= (act_q.len == DEF_LEN_W'(1));
            end else if (go_idle) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (store_pend) begin
                pend_q <= in_frame;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != EMPTY);

endmodule

// File: tb/tb_stream_serializer.sv
module tb_stream_serializer;
    import serializer_pkg::*;

    localparam int IN_W = 256;
    localparam int OUT_W = 8;
    localparam int MAXW = 32;
    localparam int LW = 6;

    localparam logic [255:0] FA =
        256'h9b26a9d1_5e7c0b38_12f4a6e0_3d8b5c71_0a9f2e64_b7c31d58_e6047fa2_c4f34076;
    localparam logic [255:0] FB =
        256'h303f1c2b_96a4e57d_0c8f31b2_6e59da07_41c8b3f6_2a9d05e8_b17c64f9_77e18d5a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [IN_W-1:0]  in_data;
    logic [LW-1:0]    in_len;
    logic             in_msb_first;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic             busy;

    stream_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_len       (in_len),
        .in_msb_first (in_msb_first),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of expected output words ----------------
    typedef struct {
        logic [7:0] w;
        bit         last;
    } word_t;
    word_t exp_q[$];
    int    sb_nfr;

    task automatic push_frame(input logic [255:0] d, input logic [LW-1:0] len, input logic msb);
        int    l;
        word_t e;
        l = (int'(len) > MAXW) ? MAXW : int'(len);
        for (int i = 0; i < l; i++) begin
            e.w    = msb ? d[255 - 8*i -: 8] : d[8*i +: 8];
            e.last = (i == l - 1);
            exp_q.push_back(e);
        end
    endtask

    // Inputs only change #1 after posedge, so the negedge sees stable values and
    // predicts what the next posedge will do.
    always @(negedge clk) begin
        if (reset) begin
            chk1("in_ready_in_reset", in_ready, 1'b0);
            exp_q.delete();
        end else begin
            sb_nfr = 0;
            foreach (exp_q[i]) if (exp_q[i].last) sb_nfr++;
            chk1("in_ready", in_ready, sb_nfr < 2);
            chk1("out_valid", out_valid, exp_q.size() != 0);
            chk1("busy", busy, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                chk8("out_data", out_data, exp_q[0].w);
                chk1("out_last", out_last, exp_q[0].last);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) push_frame(in_data, in_len, in_msb_first);
        end
    end

    // ---------------- driver helpers ----------------
    logic [7:0] got_w [0:127];

    task automatic send(input logic [255:0] d, input int len, input bit msb);
        bit ok;
        in_data      = d;
        in_len       = LW'(len);
        in_msb_first = msb;
        in_valid     = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Gathers consecutive valid words (out_ready assumed 1); a gap ends collection.
    task automatic collect(output int cnt, output int nlast, output bit last_ok);
        cnt = 0;
        nlast = 0;
        last_ok = 1'b0;
        for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            if (!out_valid) break;
            got_w[cnt] = out_data;
            if (out_last) nlast++;
            last_ok = out_last;
            cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [255:0] data;
        int           len;
        bit           msb;
        int           cnt;
        logic [7:0]   first;
        logic [7:0]   last;
    } vec_t;

    vec_t tbl [0:6];

    function automatic logic [255:0] rand256();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, nl;
        bit lok;

        tbl[0] = '{FA, 32, 1'b1, 32, 8'h9b, 8'h76};
        tbl[1] = '{FA,  4, 1'b0,  4, 8'h76, 8'hc4};
        tbl[2] = '{FA,  1, 1'b1,  1, 8'h9b, 8'h9b};
        tbl[3] = '{FA,  0, 1'b1,  0, 8'h00, 8'h00};
        tbl[4] = '{FA, 40, 1'b0, 32, 8'h76, 8'h9b};
        tbl[5] = '{FB,  2, 1'b1,  2, 8'h30, 8'h3f};
        tbl[6] = '{FB,  3, 1'b0,  3, 8'h5a, 8'he1};

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_len = '0;
        in_msb_first = 1'b0;
        out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk8("rst_out_data", out_data, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // table-driven single frames
        for (int t = 0; t < 7; t++) begin
            send(tbl[t].data, tbl[t].len, tbl[t].msb);
            collect(cnt, nl, lok);
            chkn($sformatf("t%0d_count", t), cnt, tbl[t].cnt);
            chkn($sformatf("t%0d_nlast", t), nl, (tbl[t].cnt > 0) ? 1 : 0);
            if (tbl[t].cnt > 0) begin
                chk8($sformatf("t%0d_first", t), got_w[0], tbl[t].first);
                chk8($sformatf("t%0d_last", t), (cnt > 0) ? got_w[cnt-1] : 8'h00, tbl[t].last);
                chk1($sformatf("t%0d_last_flag", t), lok, 1'b1);
            end
            chk1($sformatf("t%0d_busy_after", t), busy, 1'b0);
        end

        // back-to-back frames without bubbles
        send(FA, 32, 1'b1);
        fork
            send(FB, 32, 1'b1);
            collect(cnt, nl, lok);
            begin
                @(negedge clk);
                @(negedge clk);
                chk1("b2b_in_ready_full", in_ready, 1'b0);
                chk1("b2b_busy_full", busy, 1'b1);
            end
        join
        chkn("b2b_count", cnt, 64);
        chkn("b2b_nlast", nl, 2);
        chk8("b2b_w31", got_w[31], 8'h76);
        chk8("b2b_w32", got_w[32], 8'h30);
        chk8("b2b_w63", got_w[63], 8'h5a);

        // output stall: out_ready 1,0,0,1
        send(FA, 8, 1'b1);
        @(negedge clk);
        chk8("stall_w0", out_data, 8'h9b);
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        chk8("stall_w1_a", out_data, 8'h26);
        @(posedge clk); #1;
        @(negedge clk);
        chk8("stall_w1_b", out_data, 8'h26);
        chk1("stall_valid_held", out_valid, 1'b1);
        chk1("stall_last_held", out_last, 1'b0);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        chk8("stall_w1_c", out_data, 8'h26);
        @(posedge clk); #1;
        @(negedge clk);
        chk8("stall_w2", out_data, 8'ha9);
        @(posedge clk); #1;
        collect(cnt, nl, lok);
        chkn("stall_rest_count", cnt, 5);
        chk8("stall_rest_last", got_w[4], 8'h38);
        chk1("stall_rest_last_flag", lok, 1'b1);

        // reset with pending full
        send(FA, 32, 1'b1);
        send(FB, 32, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        send(FB, 3, 1'b0);
        collect(cnt, nl, lok);
        chkn("midrst_new_count", cnt, 3);
        chk8("midrst_new_first", got_w[0], 8'h5a);

        // randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            in_valid     = ($urandom_range(0, 2) != 0);
            in_len       = LW'($urandom_range(0, 40));
            in_msb_first = 1'($urandom_range(0, 1));
            in_data      = rand256();
            out_ready    = ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 399) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chkn("drain_empty", exp_q.size(), 0);
        chk1("drain_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
